// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage in front of the decoder.
// Owns the fetch PC, keeps at most one word request outstanding to
// instruction memory, buffers responses in a small in-order queue and
// presents {PC, instruction} to decode under a valid/ready handshake.
// A redirect from decode flushes the queue and discards any stale response.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   -> adds misaligned_fault; a redirect to a non-word-aligned
//                target sets it sticky and stops all further fetching.
//   undefined -> the low two bits of a redirect target are cleared.
module fetch_queue #(
    parameter int unsigned            ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC    = '0,
    parameter int unsigned            QUEUE_DEPTH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    decode_ready,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic                    valid,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [31:0]             instruction
`ifdef FETCH_MISALIGN_CHECK_EN
    ,output logic                   misaligned_fault
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~(ADDRESS_BITS'(3));
    localparam logic [ADDRESS_BITS-1:0] WORD_STEP = ADDRESS_BITS'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing outstanding
        WAIT = 2'd1,   // one live request outstanding
        KILL = 2'd2    // one stale request outstanding, its response is dropped
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDRESS_BITS-1:0] fpc;
    logic [ADDRESS_BITS-1:0] req_pc;
    logic [ADDRESS_BITS-1:0] q_addr [QUEUE_DEPTH];
    logic [31:0]             q_word [QUEUE_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;

    logic                    halted;
    logic                    response_due;
    logic [CNT_W:0]          occupancy;
    logic                    room;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    has_entry;
    logic [ADDRESS_BITS-1:0] redirect_pc;

    assign redirect_pc  = target_PC & ALIGN_MASK;
    assign response_due = (state != IDLE) && imem_rvalid;

    // A response landing this cycle already claims a slot; a same-cycle pop
    // is deliberately not credited, so issue never depends on decode_ready.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(state == WAIT && imem_rvalid);
    assign room      = occupancy < DEPTH_L;

    // Gating by reset keeps the request strobe and head outputs quiet
    // during the reset cycle itself, before the state registers clear.
    assign issue     = reset && !halted && room && !next_PC_select &&
                       ((state == IDLE) || response_due);
    assign push      = reset && (state == WAIT) && imem_rvalid && !next_PC_select;
    assign has_entry = reset && (count != '0);
    assign pop       = has_entry && decode_ready && !next_PC_select;

    assign imem_req    = issue;
    assign imem_addr   = fpc;
    assign valid       = has_entry;
    assign PC          = has_entry ? q_addr[head] : '0;
    assign instruction = has_entry ? q_word[head] : NOP;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky fault on a redirect to a non-word-aligned target.
    always_ff @(posedge clock) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (next_PC_select && (target_PC[1:0] != 2'b00)) begin
            halted <= 1'b1;
        end
    end

    assign misaligned_fault = halted;
`else
    assign halted = 1'b0;
`endif

    // Next-state logic for the outstanding-request tracker.
    always_comb begin
        next_state = state;
        if (next_PC_select) begin
            next_state = ((state != IDLE) && !imem_rvalid) ? KILL : IDLE;
        end else if (issue) begin
            next_state = WAIT;
        end else if (response_due) begin
            next_state = IDLE;
        end
    end

    // State register for the outstanding-request tracker.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fetch PC and the address of the request currently in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fpc    <= RESET_PC;
            req_pc <= '0;
        end else if (next_PC_select) begin
            fpc <= redirect_pc;
        end else if (issue) begin
            fpc    <= fpc + WORD_STEP;
            req_pc <= fpc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue in one step.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (next_PC_select) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: each entry holds the request address and returned word.
    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[tail] <= req_pc;
            q_word[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by a
// randomized phase, with an in-order memory model of random latency and a
// scoreboard of the instruction stream decode is expected to receive.
module tb_fetch_queue;

    localparam int unsigned AB    = 16;
    localparam int unsigned DEPTH = 2;
    localparam logic [15:0] RST_PC = 16'h0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        next_PC_select = 1'b0;
    logic [15:0] target_PC = '0;
    logic        decode_ready = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        valid;
    logic [15:0] PC;
    logic [31:0] instruction;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned_fault;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fetch_queue #(
        .ADDRESS_BITS(AB),
        .RESET_PC(RST_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misaligned_fault(misaligned_fault),
`endif
        .reset(reset),
        .next_PC_select(next_PC_select),
        .target_PC(target_PC),
        .decode_ready(decode_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .valid(valid),
        .PC(PC),
        .instruction(instruction)
    );

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // ---------------- memory model ----------------
    bit          mem_pending = 1'b0;
    logic [15:0] mem_addr_q = '0;
    int unsigned mem_wait = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    // Drive the response for the current cycle.
    always @(posedge clock) begin
        #1;
        if (mem_pending && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr_q);
            mem_pending = 1'b0;
        end else begin
            if (mem_pending) mem_wait--;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    end

    // Accept a request; only one may be outstanding.
    always @(negedge clock) begin
        if (imem_req === 1'b1) begin
            checks++;
            if (mem_pending) begin
                failures++;
                $display("FAIL one_outstanding: req at %h while %h still pending", imem_addr, mem_addr_q);
            end
            mem_pending = 1'b1;
            mem_addr_q  = imem_addr;
            mem_wait    = $urandom_range(lat_max, lat_min) - 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      exp_q[$];
    logic [15:0] seq_pc = RST_PC;

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({seq_pc, mem_word(seq_pc)});
            seq_pc = seq_pc + 16'd4;
        end
    endtask

    task automatic seed(input logic [15:0] start);
        exp_q.delete();
        seq_pc = start;
        top_up();
    endtask

    // ---------------- monitor ----------------
    logic [15:0] exp_fetch = RST_PC;
    bit          live = 1'b0;
    bit          expect_valid = 1'b0;
    bit          expect_empty = 1'b0;
    int unsigned req_count = 0;
    int unsigned pop_count = 0;

    always @(negedge clock) begin
        entry_t e;
        if (reset !== 1'b1) begin
            exp_fetch    = RST_PC;
            live         = 1'b0;
            expect_valid = 1'b0;
            expect_empty = 1'b0;
        end else begin
            if (expect_valid) begin
                checks++;
                if (valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rsp_to_valid: valid=%b required 1", valid);
                end
            end
            if (expect_empty) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("FAIL redirect_flush: valid=%b required 0", valid);
                end
            end
            expect_valid = imem_rvalid && live && !next_PC_select;
            expect_empty = next_PC_select;
            if (next_PC_select) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL redirect_req: imem_req=%b required 0", imem_req);
                end
                exp_fetch = target_PC & 16'hFFFC;
                live = 1'b0;
            end else begin
                if (valid === 1'b1 && decode_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL pop_underflow: pop of PC=%h with nothing expected", PC);
                    end else begin
                        e = exp_q.pop_front();
                        pop_count++;
                        if (PC !== e.pc || instruction !== e.ins) begin
                            failures++;
                            $display("FAIL pop_data: got PC=%h ins=%h required PC=%h ins=%h",
                                     PC, instruction, e.pc, e.ins);
                        end
                    end
                end
                if (imem_rvalid) live = 1'b0;
                if (imem_req === 1'b1) begin
                    checks++;
                    if (imem_addr !== exp_fetch) begin
                        failures++;
                        $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_fetch);
                    end
                    exp_fetch = exp_fetch + 16'd4;
                    live = 1'b1;
                    req_count++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int unsigned req_base = 0;

    task automatic cyc();
        @(posedge clock);
        #2;
        top_up();
    endtask

    task automatic redirect(input logic [15:0] t);
        next_PC_select = 1'b1;
        target_PC = t;
        seed(t & 16'hFFFC);
        cyc();
        next_PC_select = 1'b0;
    endtask

    task automatic do_reset(input int unsigned n);
        reset = 1'b0;
        next_PC_select = 1'b0;
        seed(RST_PC);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clock);
            checks++;
            if (valid !== 1'b0 || PC !== 16'h0 || instruction !== NOP || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: valid=%b PC=%h ins=%h req=%b required 0 0000 %h 0",
                         valid, PC, instruction, imem_req, NOP);
            end
            cyc();
        end
        for (int i = 0; i < 8 && mem_pending; i++) cyc();
        if (mem_pending) begin
            failures++;
            $display("FAIL reset_drain: memory response still pending=%b required 0", mem_pending);
        end
        reset = 1'b1;
        req_base = req_count;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RST_PC);
        end
        cyc();
    endtask

    initial begin
        bit found;
        int unsigned r;
        logic [15:0] t;

        // Latency 1, decode always ready: requests 0100, 0104; head valid in cycle 3.
        lat_min = 1; lat_max = 1; decode_ready = 1'b1;
        do_reset(2);
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0104) begin
            failures++;
            $display("FAIL second_req: req=%b addr=%h required 1 0104", imem_req, imem_addr);
        end
        cyc();
        @(negedge clock);
        checks++;
        if (valid !== 1'b1 || PC !== 16'h0100) begin
            failures++;
            $display("FAIL first_valid: valid=%b PC=%h required 1 0100", valid, PC);
        end
        repeat (10) cyc();

        // Decode stalled: exactly QUEUE_DEPTH requests, head held at 0100.
        decode_ready = 1'b0;
        do_reset(2);
        repeat (12) cyc();
        @(negedge clock);
        checks++;
        if (req_count - req_base != DEPTH || valid !== 1'b1 || PC !== 16'h0100) begin
            failures++;
            $display("FAIL full_stall: reqs=%0d valid=%b PC=%h required %0d 1 0100",
                     req_count - req_base, valid, PC, DEPTH);
        end
        decode_ready = 1'b1;
        repeat (6) cyc();

        // Redirect while WAIT at latency 3: stale response dropped.
        lat_min = 3; lat_max = 3;
        do_reset(2);
        redirect(16'h0200);
        cyc();
        cyc();
        @(negedge clock);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_drop: valid=%b required 0", valid);
        end
        repeat (15) cyc();

        // Reset during WAIT, late response arrives in IDLE and is ignored.
        do_reset(2);
        do_reset(1);
        @(negedge clock);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL late_rsp_ignored: valid=%b required 0", valid);
        end
        repeat (10) cyc();

        // Redirect coinciding with a response and a pop.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (valid === 1'b1 && imem_rvalid === 1'b1) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL coincide_setup: valid with rvalid seen=%b required 1", found);
        end
        redirect(16'h0200);
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0200 || valid !== 1'b0) begin
            failures++;
            $display("FAIL coincide_redirect: req=%b addr=%h valid=%b required 1 0200 0",
                     imem_req, imem_addr, valid);
        end
        repeat (10) cyc();

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            decode_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 199);
            if (r < 8) begin
                t = 16'($urandom);
`ifdef FETCH_MISALIGN_CHECK_EN
                t = t & 16'hFFFC;
`endif
                redirect(t);
            end else if (r == 199) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cyc();
            end
        end

        // Misaligned redirect target.
        lat_min = 1; lat_max = 1; decode_ready = 1'b1;
        do_reset(2);
        repeat (4) cyc();
        redirect(16'h0202);
`ifdef FETCH_MISALIGN_CHECK_EN
        req_base = req_count;
        @(negedge clock);
        checks++;
        if (misaligned_fault !== 1'b1) begin
            failures++;
            $display("FAIL misalign_fault: misaligned_fault=%b required 1", misaligned_fault);
        end
        repeat (20) cyc();
        @(negedge clock);
        checks++;
        if (req_count != req_base || valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_halt: reqs=%0d valid=%b required 0 0", req_count - req_base, valid);
        end
`else
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (imem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!found || imem_addr !== 16'h0200) begin
            failures++;
            $display("FAIL misalign_clear: req seen=%b addr=%h required 1 0200", found, imem_addr);
        end
        repeat (10) cyc();
`endif

        checks++;
        if (pop_count < 300) begin
            failures++;
            $display("FAIL progress: pops=%0d required at least 300", pop_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage feeding the decoder.
- Owns the fetch PC and issues word requests to instruction memory.
- Buffers returned instructions in a small in-order queue and presents `{PC, instruction}` to decode under a valid/ready handshake.
- Applies redirects (`next_PC_select`, `target_PC`) from decode by flushing the queue and discarding any in-flight stale response.

## Interface
- `ADDRESS_BITS`, 16: width of all PCs and memory addresses.
- `RESET_PC`, 0: fetch address after reset.
- `QUEUE_DEPTH`, 2: number of instruction queue entries; a power of two, at least 2.

- `clock` input 1: sole clock; every state element updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clock` rising edge.
- `next_PC_select` input 1: redirect request from decode.
- `target_PC` input `ADDRESS_BITS`: redirect target.
- `decode_ready` input 1: decode accepts the head entry this cycle.
- `imem_req` output 1: request strobe, combinational.
- `imem_addr` output `ADDRESS_BITS`: request address, equal to the fetch PC.
- `imem_rvalid` input 1: response valid, returned in order; latency is at least 1 cycle.
- `imem_rdata` input 32: response instruction word.
- `valid` output 1: queue head is valid.
- `PC` output `ADDRESS_BITS`: PC of the queue head.
- `instruction` output 32: instruction of the queue head.

## Operation
- Registered state:
  - `fpc`, the next fetch address.
  - Queue storage holding `{addr, word}` pairs, with head and tail pointers and `count`.
  - A 2-bit FSM: IDLE (nothing outstanding), WAIT (one live request outstanding), KILL (one stale request outstanding).
- At most one request is outstanding at any time.
- `room` = `count` + (1 if the state is WAIT and `imem_rvalid`) < `QUEUE_DEPTH`. A same-cycle pop is ignored in this calculation.
- Request issue:
  - `imem_req` = `room` && !`next_PC_select` && (state==IDLE || (state!=IDLE && `imem_rvalid`)).
  - On issue: `fpc` <= `fpc`+4, and the next state is WAIT.
  - Responses back-to-back with new requests sustain one instruction per cycle at latency 1.
- The issued address is tracked in a register `req_pc`.
- Response handling:
  - In WAIT with `imem_rvalid` and no redirect: push `{req_pc, imem_rdata}`. The next state is WAIT if a new request issues that cycle, otherwise IDLE.
  - In KILL with `imem_rvalid`: the response is dropped, and the next state is WAIT if a new request issues that cycle, otherwise IDLE.
  - `imem_rvalid` in IDLE is ignored.
- Pop: when `valid` && `decode_ready`, the head pointer advances.
- A push and a pop may occur in the same cycle; `count` is then unchanged.
- Redirect (`next_PC_select`=1, which has priority over everything else):
  - Queue flushed: `count` <= 0, head <= tail.
  - `fpc` <= {`target_PC`[ADDRESS_BITS-1:2], 2'b00}.
  - `imem_req` = 0 in that cycle.
  - Next state: from WAIT or KILL without `imem_rvalid`, KILL; with `imem_rvalid`, IDLE (the response is dropped); from IDLE, IDLE.
  - A push or pop in the same cycle is suppressed.
- Output mux: while `count`==0, `valid`=0, `instruction`=32'h00000013 (NOP) and `PC`=0. Otherwise they show the head entry.

## Timing
- Reset values:
  - `fpc`=`RESET_PC`, state IDLE, `count`=0.
  - Outputs: `valid`=0, `PC`=0, `instruction`=NOP, `imem_req`=0 during the reset cycle.
- First `imem_req`, with `imem_addr`=`RESET_PC`, occurs in the first cycle after `reset` deasserts.
- Response to output: `imem_rvalid` in cycle T gives `valid`=1 in T+1 with that word.
- Redirect sampled at edge T:
  - `valid`=0 in T+1.
  - If IDLE, `imem_req` with `imem_addr`=target in T+1.
  - Earliest valid target instruction at T+1+L+1, where L is the memory latency.
- Queue full (`count`==`QUEUE_DEPTH`): no request issues.
- A reset in the middle of an outstanding request returns to IDLE. A late `imem_rvalid` arriving in IDLE is ignored.
- Pointers wrap modulo `QUEUE_DEPTH`.

## Configuration
- Macro `FETCH_MISALIGN_CHECK_EN`.
- Defined:
  - Extra output `misaligned_fault` (1 bit, reset 0).
  - A redirect with `target_PC`[1:0]!=0 sets `misaligned_fault` sticky until reset.
  - After the fault, `imem_req` is held at 0 permanently and the queue stays empty.
- Undefined: no port is added; the low two bits of a redirect target are silently cleared.

## Test plan
- Reset with `RESET_PC`=16'h0100, latency-1 memory, `decode_ready`=1 -> `imem_addr` 0100, 0104, 0108 on consecutive cycles; `valid` high from cycle 3 with `PC` following one cycle behind the responses.
- `decode_ready`=0 with depth 2 -> exactly 2 entries fill, `imem_req` stays 0 after that, head held at `PC`=0100.
- Redirect to 16'h0200 while WAIT, latency 3 -> stale response dropped (state KILL), queue empty, next `imem_addr`=0200, first valid `PC`=0200.
- Redirect in the same cycle as `imem_rvalid` and a pop -> no push, no pop, `count`=0, next state IDLE, `imem_req` with 0200 the following cycle.
- Reset asserted during WAIT, then `imem_rvalid` arrives -> ignored, `valid` stays 0, next request at `RESET_PC`.
- `FETCH_MISALIGN_CHECK_EN` defined, redirect to 16'h0202 -> `misaligned_fault`=1 next cycle, no further `imem_req`. Undefined: fetch resumes at 0200.
